// File: rtl/lane_queue_pkg.sv
// Shared types and configuration check for the multi-lane queue and lane compaction logic.
package lane_queue_pkg;

  localparam int LQ_MAX_LANES = 8;

  typedef logic [$clog2(LQ_MAX_LANES)-1:0]   lane_idx_t;
  typedef logic [$clog2(LQ_MAX_LANES+1)-1:0] lane_cnt_t;

  // Depth must be a power of two so pointers wrap for free, and hold two full lane groups.
  function automatic bit lq_cfg_ok(input int lanes, input int depth);
    return (lanes >= 1) && (lanes <= LQ_MAX_LANES) &&
           (depth >= 2 * lanes) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/lane_queue_if.sv
// Producer/consumer bundle of the lane queue: enqueue lanes, dequeue lanes, flush and occupancy.
interface lane_queue_if #(
  parameter int WIDTH = 64,
  parameter int LANES = 2,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                         flush;
  logic [LANES-1:0]             enq_valid;
  logic [LANES-1:0][WIDTH-1:0]  enq_data;
  logic                         enq_ready;
  logic [LANES-1:0]             deq_valid;
  logic [LANES-1:0][WIDTH-1:0]  deq_data;
  logic [LANES-1:0]             deq_ready;
  logic [CW-1:0]                count;

  modport master (
    output flush, enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count
  );

  modport slave (
    input  flush, enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count
  );
endinterface

// File: rtl/lane_queue_compact.sv
// lane_compact: packs sparse valid lanes to the low lanes in lane order and counts them.
// Purely combinational.
module lane_compact
  import lane_queue_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]             i_vld,
  input  logic [LANES-1:0][WIDTH-1:0]  i_dat,
  output logic [LANES-1:0]             o_vld,
  output logic [LANES-1:0][WIDTH-1:0]  o_dat,
  output lane_cnt_t                    o_cnt
);

  lane_cnt_t w_pos;

  always_comb begin
    w_pos = '0;
    o_dat = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (i_vld[i] && (w_pos == lane_cnt_t'(j))) o_dat[j] = i_dat[i];
      end
      w_pos = w_pos + lane_cnt_t'(i_vld[i]);
    end
  end

  always_comb begin
    o_vld = '0;
    for (int i = 0; i < LANES; i++) o_vld[i] = (lane_cnt_t'(i) < w_pos);
  end

  assign o_cnt = w_pos;

endmodule

// File: rtl/lane_queue.sv
// lane_queue: multi-lane elastic FIFO with in-order multi-entry dequeue and single-cycle flush.
// Optional zero-latency empty-queue bypass enabled by defining LANE_QUEUE_BYPASS_EN.
module lane_queue
  import lane_queue_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  lane_queue_if.slave  q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (!lq_cfg_ok(LANES, DEPTH)) begin : g_cfg_err
    $error("lane_queue: illegal LANES/DEPTH combination");
  end

  logic [WIDTH-1:0]            r_mem [DEPTH];
  logic [PW-1:0]               r_head;
  logic [PW-1:0]               r_tail;
  logic [CW-1:0]               r_count;

  logic                        w_enq_rdy;
  logic                        w_enq_fire;
  logic [LANES-1:0]            w_cmp_vld;
  logic [LANES-1:0][WIDTH-1:0] w_cmp_dat;
  lane_cnt_t                   w_n_enq;
  logic [LANES-1:0]            w_mem_vld;
  logic [LANES-1:0][WIDTH-1:0] w_mem_dat;
  logic [LANES-1:0]            w_deq_vld;
  logic [LANES-1:0][WIDTH-1:0] w_deq_dat;
  lane_cnt_t                   w_n_deq;
  lane_cnt_t                   w_skip;
  lane_cnt_t                   w_n_pop;
  lane_cnt_t                   w_n_add;
  logic                        w_run;
  logic                        w_rdy_prefix;

  lane_compact #(.WIDTH(WIDTH), .LANES(LANES)) u_compact (
    .i_vld (q.enq_valid),
    .i_dat (q.enq_data),
    .o_vld (w_cmp_vld),
    .o_dat (w_cmp_dat),
    .o_cnt (w_n_enq)
  );

  // Readiness looks only at registered occupancy, so deq_ready never reaches enq_ready.
  assign w_enq_rdy  = (r_count <= CW'(DEPTH - LANES));
  assign w_enq_fire = w_enq_rdy && !q.flush;

  always_comb begin
    w_mem_vld = '0;
    w_mem_dat = '0;
    for (int i = 0; i < LANES; i++) begin
      w_mem_vld[i] = (r_count > CW'(i)) && !q.flush;
      w_mem_dat[i] = r_mem[r_head + PW'(i)];
    end
  end

`ifdef LANE_QUEUE_BYPASS_EN
  logic w_byp;
  // Empty queue: incoming lanes are presented directly; taken ones never touch storage.
  assign w_byp     = (r_count == '0) && w_enq_fire;
  assign w_deq_vld = w_byp ? w_cmp_vld : w_mem_vld;
  assign w_deq_dat = w_byp ? w_cmp_dat : w_mem_dat;
  assign w_skip    = w_byp ? w_n_deq : '0;
  assign w_n_pop   = w_byp ? '0 : w_n_deq;
`else
  assign w_deq_vld = w_mem_vld;
  assign w_deq_dat = w_mem_dat;
  assign w_skip    = '0;
  assign w_n_pop   = w_n_deq;
`endif

  // Only the leading run of valid&&ready lanes is consumed.
  always_comb begin
    w_n_deq = '0;
    w_run   = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      w_run   = w_run & w_deq_vld[i] & q.deq_ready[i];
      w_n_deq = w_n_deq + lane_cnt_t'(w_run);
    end
  end

  assign w_n_add = w_enq_fire ? (w_n_enq - w_skip) : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_enq_fire && w_cmp_vld[i] && (lane_cnt_t'(i) >= w_skip))
        r_mem[r_tail + PW'(i) - PW'(w_skip)] <= w_cmp_dat[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (q.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_pop);
      r_tail  <= r_tail + PW'(w_n_add);
      r_count <= r_count + CW'(w_n_add) - CW'(w_n_pop);
    end
  end

  assign q.enq_ready = w_enq_rdy;
  assign q.deq_valid = w_deq_vld;
  assign q.deq_data  = w_deq_dat;
  assign q.count     = r_count;

  assign w_rdy_prefix = ((q.deq_ready & (q.deq_ready + LANES'(1))) == '0);

  a_deq_ready_prefix: assert property (@(posedge clk) disable iff (!resetn) w_rdy_prefix);

endmodule

// File: tb/tb_lane_queue.sv
// Bench for lane_queue: vector table plus scoreboard of expected dequeue order.
module tb_lane_queue;

  localparam int W = 64;
  localparam int L = 2;
  localparam int D = 8;
`ifdef LANE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  lane_queue_if #(.WIDTH(W), .LANES(L), .DEPTH(D)) q ();

  lane_queue #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (q)
  );

  typedef struct {
    logic        fl;
    logic [1:0]  ev;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  dr;
    int          cnt;
    logic        rdy;
    logic [1:0]  vld;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic add(input logic fl, input logic [1:0] ev, input logic [63:0] d0,
                     input logic [63:0] d1, input logic [1:0] dr, input int cnt,
                     input logic rdy, input logic [1:0] vld);
    vec_t v;
    v.fl = fl; v.ev = ev; v.d0 = d0; v.d1 = d1; v.dr = dr;
    v.cnt = cnt; v.rdy = rdy; v.vld = vld;
    tbl.push_back(v);
  endtask

  // One cycle: drive at negedge, compare outputs against expectations and the scoreboard.
  task automatic step(input string nm, input logic fl, input logic [1:0] ev,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] dr,
                      input int e_cnt, input logic e_rdy, input logic [1:0] e_vld);
    logic [63:0] enq[$];
    bit fire, run;
    int n;
    @(negedge clk);
    q.flush = fl; q.enq_valid = ev; q.enq_data[0] = d0; q.enq_data[1] = d1; q.deq_ready = dr;
    #1;
    chk({nm, ".count"},     64'(q.count),     64'(e_cnt));
    chk({nm, ".enq_ready"}, 64'(q.enq_ready), 64'(e_rdy));
    chk({nm, ".deq_valid"}, 64'(q.deq_valid), 64'(e_vld));
    fire = ((D - sb.size()) >= L) && !fl;
    if (fire) begin
      if (ev[0]) enq.push_back(d0);
      if (ev[1]) enq.push_back(d1);
    end
    if (BYP && fire && sb.size() == 0) begin
      sb = enq;
      enq.delete();
    end
    n = 0;
    run = 1'b1;
    if (!fl) begin
      for (int i = 0; i < L; i++) begin
        if (i < sb.size()) begin
          chk($sformatf("%s.deq_data%0d", nm, i), q.deq_data[i], sb[i]);
          run = run && dr[i];
          if (run) n++;
        end
      end
    end
    repeat (n) void'(sb.pop_front());
    foreach (enq[k]) sb.push_back(enq[k]);
    if (fl) sb.delete();
  endtask

  initial begin
    logic [1:0] v0;
    v0 = BYP ? 2'b11 : 2'b00;
    // fill to full, refuse, partial drains
    add(0, 2'b11, 64'hA0, 64'hA1, 2'b00, 0, 1, v0);
    add(0, 2'b11, 64'hA2, 64'hA3, 2'b00, 2, 1, 2'b11);
    add(0, 2'b11, 64'hA4, 64'hA5, 2'b00, 4, 1, 2'b11);
    add(0, 2'b11, 64'hA6, 64'hA7, 2'b00, 6, 1, 2'b11);
    add(0, 2'b11, 64'hEE, 64'hEF, 2'b00, 8, 0, 2'b11);
    add(0, 2'b00, 64'h0,  64'h0,  2'b11, 8, 0, 2'b11);
    add(0, 2'b00, 64'h0,  64'h0,  2'b01, 6, 1, 2'b11);
    add(0, 2'b00, 64'h0,  64'h0,  2'b11, 5, 1, 2'b11);
    add(0, 2'b00, 64'h0,  64'h0,  2'b01, 3, 1, 2'b11);
    add(0, 2'b00, 64'h0,  64'h0,  2'b11, 2, 1, 2'b11);
    add(0, 2'b00, 64'h0,  64'h0,  2'b00, 0, 1, 2'b00);
    // sparse lane-1 enqueue lands in lane 0
    add(0, 2'b10, 64'hDD, 64'hB0, 2'b00, 0, 1, BYP ? 2'b01 : 2'b00);
    add(0, 2'b00, 64'h0,  64'h0,  2'b01, 1, 1, 2'b01);
    // count 7 blocks enqueue even while dequeuing
    add(0, 2'b11, 64'hC0, 64'hC1, 2'b00, 0, 1, v0);
    add(0, 2'b11, 64'hC2, 64'hC3, 2'b00, 2, 1, 2'b11);
    add(0, 2'b11, 64'hC4, 64'hC5, 2'b00, 4, 1, 2'b11);
    add(0, 2'b01, 64'hC6, 64'hCF, 2'b00, 6, 1, 2'b11);
    add(0, 2'b11, 64'hE0, 64'hE1, 2'b00, 7, 0, 2'b11);
    add(0, 2'b11, 64'hE2, 64'hE3, 2'b01, 7, 0, 2'b11);
    add(0, 2'b11, 64'hD0, 64'hD1, 2'b00, 6, 1, 2'b11);
    add(0, 2'b00, 64'h0,  64'h0,  2'b11, 8, 0, 2'b11);
    add(0, 2'b00, 64'h0,  64'h0,  2'b01, 6, 1, 2'b11);
    // flush at count 5 with enq and deq requested
    add(1, 2'b11, 64'hF0, 64'hF1, 2'b11, 5, 1, 2'b00);
    add(0, 2'b00, 64'h0,  64'h0,  2'b00, 0, 1, 2'b00);
    add(0, 2'b11, 64'h10, 64'h11, 2'b00, 0, 1, v0);
    add(0, 2'b11, 64'h12, 64'h13, 2'b00, 2, 1, 2'b11);

    resetn = 1'b0;
    q.flush = 1'b0; q.enq_valid = '0; q.enq_data = '0; q.deq_ready = '0;
    #12;
    chk("reset.count",     64'(q.count),     64'd0);
    chk("reset.enq_ready", 64'(q.enq_ready), 64'd1);
    chk("reset.deq_valid", 64'(q.deq_valid), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i])
      step($sformatf("v%0d", i), tbl[i].fl, tbl[i].ev, tbl[i].d0, tbl[i].d1, tbl[i].dr,
           tbl[i].cnt, tbl[i].rdy, tbl[i].vld);

    // steady full-width streaming across pointer wrap
    for (int k = 0; k < 20; k++)
      step($sformatf("ss%0d", k), 1'b0, 2'b11, 64'h2000 + 64'(2 * k), 64'h2001 + 64'(2 * k),
           2'b11, 4, 1'b1, 2'b11);

    // asynchronous reset between clock edges
    @(negedge clk);
    q.flush = 1'b0; q.enq_valid = 2'b11; q.deq_ready = '0;
    @(posedge clk);
    #2;
    chk("prerst.count", 64'(q.count), 64'(sb.size() + 2));
    resetn = 1'b0;
    #1;
    chk("arst.count",     64'(q.count),     64'd0);
    chk("arst.deq_valid", 64'(q.deq_valid), 64'd0);
    chk("arst.enq_ready", 64'(q.enq_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    q.enq_valid = '0;
    resetn = 1'b1;

    // enqueue into empty queue while consumer is fully ready
    step("rz0", 1'b0, 2'b11, 64'h30, 64'h31, 2'b11, 0, 1'b1, BYP ? 2'b11 : 2'b00);
    step("rz1", 1'b0, 2'b00, 64'h0,  64'h0,  2'b11, BYP ? 0 : 2, 1'b1, BYP ? 2'b00 : 2'b11);
    step("rz2", 1'b0, 2'b00, 64'h0,  64'h0,  2'b00, 0, 1'b1, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
